lsu: RTL and testbench

Load/store unit between the MEM pipeline stage and the 256-byte data memory `dmem`. It accepts one memory request at a time over a valid/ready handshake. It performs byte, halfword and word loads with sign or zero extension. Sub-word stores use read-modify-write on the word-wide memory port. It flags misaligned and out-of-range accesses without touching memory. The memory is always addressed word-aligned, so `dmem`'s byte-address wrap is never exercised.

---
 rtl/lsu_if.sv | 23 ++
 rtl/lsu.sv | 131 +++++++++++++
 tb/tb_lsu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request/response handshake between the MEM stage (master) and the load/store unit (slave).
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time to a word-wide data memory, sub-word stores
// via read-modify-write, misaligned/out-of-range/illegal-size requests rejected early.
module lsu #(
   parameter int unsigned DMEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst,
   lsu_if.slave        bus,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

   state_e      state;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;

   logic        req_bad;
   logic [31:0] lane;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign bus.req_ready  = (state == StIdle);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

   always_comb begin
      req_bad = (bus.req_size == 2'b11)
             || ((bus.req_size == 2'b01) && bus.req_addr[0])
             || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
             || (bus.req_addr >= 32'(DMEM_BYTES));
   end

   always_comb begin
      lane = mem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b00:   load_val = unsigned_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         2'b01:   load_val = unsigned_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_val = mem_rdata;
      endcase

      merged = mem_rdata;
      if (size_q == 2'b00) begin
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= StIdle;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         off_q        <= 2'b00;
         wdata_q      <= 16'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'h0;
         mem_wdata    <= 32'h0;
      end else begin
         case (state)
            StIdle: begin
               if (bus.req_valid) begin
                  size_q     <= bus.req_size;
                  unsigned_q <= bus.req_unsigned;
                  off_q      <= bus.req_addr[1:0];
                  wdata_q    <= bus.req_wdata[15:0];
                  mem_addr   <= {bus.req_addr[31:2], 2'b00};
                  if (req_bad) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                     state        <= StResp;
                  end else if (!bus.req_we) begin
                     state <= StLoad;
                  end else if (bus.req_size == 2'b10) begin
                     // Word store needs no read, so the write is issued straight away.
                     mem_we    <= 1'b1;
                     mem_wdata <= bus.req_wdata;
                     state     <= StWrite;
                  end else begin
                     state <= StMerge;
                  end
               end
            end
            StLoad: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= load_val;
               state        <= StResp;
            end
            StMerge: begin
               mem_we    <= 1'b1;
               mem_wdata <= merged;
               state     <= StWrite;
            end
            StWrite: begin
               mem_we       <= 1'b0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'h0;
               state        <= StResp;
            end
            StResp: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'h0;
               mem_addr     <= 32'h0;
               state        <= StIdle;
            end
            default: begin
               mem_we <= 1'b0;
               state  <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a word-wide memory model and a queue of expected responses.
module tb_lsu;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          wes;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        mem_clr;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] mem [64];

   int   checks;
   int   failures;
   exp_t sb_q[$];

   lsu_if bus ();

   lsu #(.DMEM_BYTES(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (mem_we) begin
         mem[mem_addr[7:2]] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
   endtask

   task automatic push(input logic [31:0] rdata, input logic err, input int lat, input int wes);
      exp_t e;
      e.rdata = rdata;
      e.err   = err;
      e.lat   = lat;
      e.wes   = wes;
      sb_q.push_back(e);
   endtask

   // Waits a bounded number of cycles for the response, then checks it against the queue head.
   task automatic wait_resp(input string tag);
      exp_t e;
      int   nwe = 0;
      int   lat = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (mem_we) nwe++;
         if (bus.resp_valid) begin
            lat = c;
            break;
         end
      end
      e = sb_q.pop_front();
      check({tag, ".lat"}, 32'(lat), 32'(e.lat));
      check({tag, ".rdata"}, bus.resp_rdata, e.rdata);
      check({tag, ".err"}, {31'h0, bus.resp_err}, {31'h0, e.err});
      check({tag, ".we_cycles"}, 32'(nwe), 32'(e.wes));
   endtask

   task automatic txn(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_wes);
      push(exp_rdata, exp_err, exp_lat, exp_wes);
      @(negedge clk);
      check({tag, ".ready"}, {31'h0, bus.req_ready}, 32'h1);
      drive(we, size, uns, addr, wdata);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wait_resp(tag);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      mem_clr  = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst.resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("rst.resp_rdata", bus.resp_rdata, 32'h0);
      check("rst.resp_err", {31'h0, bus.resp_err}, 32'h0);
      check("rst.mem_we", {31'h0, mem_we}, 32'h0);
      check("rst.mem_addr", mem_addr, 32'h0);
      check("rst.mem_wdata", mem_wdata, 32'h0);
      rst     = 1'b0;
      mem_clr = 1'b0;

      // Word store / load round trip
      txn("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 2, 1);
      txn("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 2, 0);

      // Byte store keeps neighbouring bytes
      txn("sw04", 1'b1, 2'b10, 1'b0, 32'h04, 32'h1122_3344, 32'h0, 1'b0, 2, 1);
      txn("sb05", 1'b1, 2'b00, 1'b0, 32'h05, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1);
      txn("lw04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h1122_AB44, 1'b0, 2, 0);
      txn("lbu07", 1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 32'h0000_0011, 1'b0, 2, 0);
      txn("lh06", 1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 32'h0000_1122, 1'b0, 2, 0);

      // Sign and zero extension
      txn("sb08", 1'b1, 2'b00, 1'b0, 32'h08, 32'hDEAD_BE80, 32'h0, 1'b0, 3, 1);
      txn("lb08", 1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
      txn("lbu08", 1'b0, 2'b00, 1'b1, 32'h08, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
      txn("sh0a", 1'b1, 2'b01, 1'b0, 32'h0A, 32'h1234_8001, 32'h0, 1'b0, 3, 1);
      txn("lh0a", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 32'hFFFF_8001, 1'b0, 2, 0);
      txn("lhu0a", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 32'h0000_8001, 1'b0, 2, 0);
      txn("lw08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h8001_0080, 1'b0, 2, 0);
      txn("lb0b", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
      txn("lbu0a", 1'b0, 2'b00, 1'b1, 32'h0A, 32'h0, 32'h0000_0001, 1'b0, 2, 0);

      // Error cases: no memory activity, response one cycle after handshake
      txn("err_lw02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("err_sh03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h5555, 32'h0, 1'b1, 1, 0);
      txn("err_sz11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("err_lw100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
      txn("err_sw100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b1, 1, 0);
      txn("lw00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 2, 0);

      // Reset during MERGE aborts the store silently
      @(negedge clk);
      drive(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_00FF);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort.merge_we", {31'h0, mem_we}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort.we", {31'h0, mem_we}, 32'h0);
      check("abort.resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("abort.ready", {31'h0, bus.req_ready}, 32'h1);
      txn("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2, 0);

      // Request held valid through a load is taken only after RESP
      push(32'h1122_AB44, 1'b0, 2, 0);
      @(negedge clk);
      drive(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
      @(posedge clk);
      #1 drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      push(32'h1234_5678, 1'b0, 2, 0);
      @(negedge clk);
      check("bp.ready_load", {31'h0, bus.req_ready}, 32'h0);
      check("bp.valid_load", {31'h0, bus.resp_valid}, 32'h0);
      @(negedge clk);
      check("bp.ready_resp", {31'h0, bus.req_ready}, 32'h0);
      check("bp.valid_resp", {31'h0, bus.resp_valid}, 32'h1);
      begin
         exp_t e;
         e = sb_q.pop_front();
         check("bp.first_rdata", bus.resp_rdata, e.rdata);
      end
      @(negedge clk);
      check("bp.ready_idle", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wait_resp("bp.second");

      check("sb.drained", 32'(sb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
